// File: rtl/nibble_addsub_seq_if.sv
// Handshake and operand/result bundle for the nibble-serial add/sub unit.
// The master drives requests; the slave (the unit) returns status and results.
interface nibble_addsub_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             flush;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovfl;
    logic             Z;
    logic             N;

    modport master (
        output start, sub, A, B, flush,
        input  ready, done, Sum, Cout, Ovfl, Z, N
    );

    modport slave (
        input  start, sub, A, B, flush,
        output ready, done, Sum, Cout, Ovfl, Z, N
    );
endinterface

// File: rtl/nibble_addsub_seq.sv
// Multi-cycle WIDTH-bit add/subtract built around one shared 4-bit CLA slice.
// Optional saturation on signed overflow is enabled by defining NIBBLE_ADDSUB_SAT_EN.
//
// state  | meaning
// IDLE   | ready for a new request, results held
// RUN    | one nibble per clock, LSB first, carry held in carry_q
// DONE   | one-cycle done pulse, new results visible
module nibble_addsub_seq #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    nibble_addsub_seq_if.slave  bus
);
    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int SH_W  = CNT_W + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   beff_q, beff_d;
    logic [WIDTH-1:0]   shadow_q, shadow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovfl_q, ovfl_d;
    logic               z_q, z_d;
    logic               n_q, n_d;

    logic [SH_W-1:0]    sh;
    logic [3:0]         a_nib, b_nib, g, p, slice_sum;
    logic [4:0]         c;
    logic [WIDTH-1:0]   raw_res, final_res;
    logic               ovf;

    // Shared carry-lookahead slice operating on the nibble selected by cnt_q.
    always_comb begin
        sh    = {cnt_q, 2'b00};
        a_nib = 4'(a_q >> sh);
        b_nib = 4'(beff_q >> sh);
        g     = a_nib & b_nib;
        p     = a_nib ^ b_nib;
        c[0]  = carry_q;
        c[1]  = g[0] | (p[0] & c[0]);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
        c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
        slice_sum = p ^ c[3:0];
    end

    // Only meaningful on the final nibble, where slice_sum is the MSB nibble.
    always_comb begin
        raw_res = {slice_sum, shadow_q[WIDTH-5:0]};
        ovf     = ~(a_q[WIDTH-1] ^ beff_q[WIDTH-1]) & (a_q[WIDTH-1] ^ slice_sum[3]);
`ifdef NIBBLE_ADDSUB_SAT_EN
        if (ovf) begin
            final_res = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            final_res = raw_res;
        end
`else
        final_res = raw_res;
`endif
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        beff_d   = beff_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovfl_d   = ovfl_q;
        z_d      = z_q;
        n_d      = n_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d      = bus.A;
                    beff_d   = bus.sub ? ~bus.B : bus.B;
                    carry_d  = bus.sub;
                    cnt_d    = '0;
                    shadow_d = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.flush) begin
                    shadow_d = '0;
                    cnt_d    = '0;
                    carry_d  = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    shadow_d = (shadow_q & ~(WIDTH'(4'hF) << sh))
                             | (WIDTH'(slice_sum) << sh);
                    carry_d  = c[4];
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NIB - 1)) begin
                        sum_d   = final_res;
                        cout_d  = c[4];
                        ovfl_d  = ovf;
                        z_d     = (final_res == '0);
                        n_d     = final_res[WIDTH-1];
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            beff_q   <= '0;
            shadow_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovfl_q   <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            beff_q   <= beff_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovfl_q   <= ovfl_d;
            z_q      <= z_d;
            n_q      <= n_d;
        end
    end

    assign bus.ready = (state_q == S_IDLE);
    assign bus.done  = (state_q == S_DONE);
    assign bus.Sum   = sum_q;
    assign bus.Cout  = cout_q;
    assign bus.Ovfl  = ovfl_q;
    assign bus.Z     = z_q;
    assign bus.N     = n_q;
endmodule

// File: tb/tb_nibble_addsub_seq.sv
// Scoreboard bench for nibble_addsub_seq: directed vectors push expected results,
// a monitor pops and compares on every done pulse.
module tb_nibble_addsub_seq;
    logic clk;
    logic rst_n;

    nibble_addsub_seq_if #(.WIDTH(16)) bus ();

    nibble_addsub_seq #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] sum;
        logic        c;
        logic        o;
        logic        z;
        logic        n;
    } exp_t;

    exp_t        sbq[$];
    int          tests;
    int          errs;
    int          done_cnt;
    logic [15:0] last_sum;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.done) begin
            exp_t e;
            done_cnt++;
            if (sbq.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("sum",  {16'h0, bus.Sum}, {16'h0, e.sum});
                check("cout", {31'h0, bus.Cout}, {31'h0, e.c});
                check("ovfl", {31'h0, bus.Ovfl}, {31'h0, e.o});
                check("z",    {31'h0, bus.Z},    {31'h0, e.z});
                check("n",    {31'h0, bus.N},    {31'h0, e.n});
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input exp_t e, input bit dup);
        int lat;
        int dc0;
        dc0 = done_cnt;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.sub   = s;
        sbq.push_back(e);
        lat = 0;
        @(negedge clk);
        lat++;
        if (dup) begin
            bus.start = 1'b1;
            bus.A     = 16'hFFFF;
            bus.B     = 16'hFFFF;
            bus.sub   = 1'b0;
        end else begin
            bus.start = 1'b0;
            bus.A     = ~a;
            bus.B     = ~b;
            bus.sub   = ~s;
        end
        check("ready_low_in_run", {31'h0, bus.ready}, 32'd0);
        check("sum_held_in_run", {16'h0, bus.Sum}, {16'h0, last_sum});
        @(negedge clk);
        lat++;
        bus.start = 1'b0;
        while (!bus.done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 32'd5);
        @(negedge clk);
        check("ready_after_done", {31'h0, bus.ready}, 32'd1);
        check("done_one_cycle", {31'h0, bus.done}, 32'd0);
        check("done_count", done_cnt, dc0 + 1);
        last_sum = e.sum;
    endtask

    task automatic check_reset_vals();
        check("rst_ready", {31'h0, bus.ready}, 32'd1);
        check("rst_done",  {31'h0, bus.done},  32'd0);
        check("rst_sum",   {16'h0, bus.Sum},   32'd0);
        check("rst_flags", {28'h0, bus.Cout, bus.Ovfl, bus.Z, bus.N}, 32'd0);
    endtask

    initial begin
        int dc0;
        tests     = 0;
        errs      = 0;
        done_cnt  = 0;
        last_sum  = 16'h0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.A     = 16'h0;
        bus.B     = 16'h0;
        bus.flush = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);

        issue(16'h1234, 16'h0FFF, 1'b0, '{16'h2233, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b0);
`ifdef NIBBLE_ADDSUB_SAT_EN
        issue(16'h7FFF, 16'h0001, 1'b0, '{16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0}, 1'b0);
`else
        issue(16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b1}, 1'b0);
`endif
        issue(16'h0005, 16'h0005, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}, 1'b0);
        issue(16'h0000, 16'h0001, 1'b1, '{16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1}, 1'b0);
`ifdef NIBBLE_ADDSUB_SAT_EN
        issue(16'h8000, 16'h0001, 1'b1, '{16'h8000, 1'b1, 1'b1, 1'b0, 1'b1}, 1'b0);
`else
        issue(16'h8000, 16'h0001, 1'b1, '{16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0}, 1'b0);
`endif
        issue(16'h1111, 16'h2222, 1'b0, '{16'h3333, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
        issue(16'h0001, 16'h0001, 1'b0, '{16'h0002, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b0);

        // flush in RUN: no done, results untouched
        dc0 = done_cnt;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 16'h8000;
        bus.B     = 16'h8000;
        bus.sub   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_ready", {31'h0, bus.ready}, 32'd1);
        check("flush_sum",   {16'h0, bus.Sum}, 32'h0002);
        repeat (6) @(negedge clk);
        check("flush_no_done", done_cnt, dc0);
        check("flush_sum_late", {16'h0, bus.Sum}, 32'h0002);

        // async reset mid-operation
        dc0 = done_cnt;
        bus.start = 1'b1;
        bus.A     = 16'h1234;
        bus.B     = 16'h1111;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        repeat (2) @(negedge clk);
        check("rst_no_done", done_cnt, dc0);
        rst_n    = 1'b1;
        last_sum = 16'h0;
        @(negedge clk);

        issue(16'h00FF, 16'h0001, 1'b0, '{16'h0100, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b0);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
